// File: rtl/wb_uart_tx_pkg.sv
// Shared types and constants for the Wishbone UART transmitter.
//   reg_sel_e  : register selected by bus address bits [3:2]
//   tx_state_e : serializer states
//   STAT_*     : bit positions inside the STATUS register
package wb_uart_tx_pkg;

    typedef enum logic [1:0] {
        REG_TXDATA   = 2'd0,
        REG_STATUS   = 2'd1,
        REG_DIVISOR  = 2'd2,
        REG_RESERVED = 2'd3
    } reg_sel_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_COUNT_LSB = 8;

    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset.
//   clk, reset          : clock and sync reset (empties the FIFO)
//   push, push_data     : write request; ignored while full
//   pop, pop_data       : read request; pop_data shows the head entry (valid when !empty)
//   full, empty, count  : occupancy, count is log2(DEPTH)+1 bits wide
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; contents are only observable after
    // a push, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Pipelined Wishbone slave wrapping an 8N1 UART transmitter.
//   i_clk, i_reset          : clock and synchronous active-high reset
//   i_wb_stb/we/addr/data   : bus request; addr[3:2] selects TXDATA/STATUS/DIVISOR/reserved
//   i_wb_sel                : access size code, accepted and ignored
//   o_wb_data, o_wb_ack     : registered response, one cycle after accept
//   o_wb_stall              : only a TXDATA write into a full FIFO stalls
//   o_tx                    : serial line, idle high, LSB first
module wb_uart_tx
    import wb_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [2:0]  i_wb_sel,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_tx
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);

    // Bits that are deliberately not decoded.
    logic unused_bits;
    assign unused_bits = ^{i_wb_sel, i_wb_addr, i_wb_data};

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    reg_sel_e         reg_sel;
    logic             accept;
    logic             push;
    logic             pop;
    logic             div_wr;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_wr_val;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_head;
    logic [31:0]      rd_data;
    tx_state_e        state_q;

    assign reg_sel = reg_sel_e'(i_wb_addr[3:2]);

    // Stall looks only at the registered count: a pop in the same cycle does
    // not let a push through, which keeps this path free of FSM logic.
    assign o_wb_stall = i_wb_stb && i_wb_we && (reg_sel == REG_TXDATA) && fifo_full;
    assign accept     = i_wb_stb && !o_wb_stall;
    assign push       = accept && i_wb_we && (reg_sel == REG_TXDATA);
    assign div_wr     = accept && i_wb_we && (reg_sel == REG_DIVISOR);

    // A zero divisor would never let the bit timer expire; store 1 instead.
    assign div_wr_val = (i_wb_data[DIV_WIDTH-1:0] == '0) ? DIV_ONE : i_wb_data[DIV_WIDTH-1:0];

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_data[STAT_FULL_BIT]                = fifo_full;
                rd_data[STAT_EMPTY_BIT]               = fifo_empty;
                rd_data[STAT_BUSY_BIT]                = (state_q != TX_IDLE);
                rd_data[STAT_COUNT_LSB +: CNT_W]      = fifo_count;
            end
            REG_DIVISOR: rd_data[DIV_WIDTH-1:0] = div_q;
            default:     rd_data = '0;
        endcase
    end

    // Reset in the accept cycle wins, so that request never sees an ack.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
            div_q     <= DIV_RESET;
        end else begin
            o_wb_ack  <= accept;
            o_wb_data <= (accept && !i_wb_we) ? rd_data : '0;
            if (div_wr) div_q <= div_wr_val;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .reset     (i_reset),
        .push      (push),
        .push_data (i_wb_data[7:0]),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    tx_state_e            state_d;
    logic [DIV_WIDTH-1:0] timer_q,     timer_d;
    logic [DIV_WIDTH-1:0] frame_div_q, frame_div_d;
    logic [7:0]           shift_q,     shift_d;
    logic [2:0]           bit_cnt_q,   bit_cnt_d;
    logic                 line_q,      line_d;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        frame_div_d = frame_div_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        pop         = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_d     = fifo_head;
                    // Divisor is frozen per frame; later writes apply from the next START.
                    frame_div_d = div_q;
                    timer_d     = div_q - DIV_ONE;
                    state_d     = TX_START;
                end
            end
            TX_START: begin
                if (timer_q == '0) begin
                    timer_d   = frame_div_q - DIV_ONE;
                    bit_cnt_d = '0;
                    state_d   = TX_DATA;
                end else begin
                    timer_d = timer_q - DIV_ONE;
                end
            end
            TX_DATA: begin
                if (timer_q == '0) begin
                    timer_d = frame_div_q - DIV_ONE;
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - DIV_ONE;
                end
            end
            TX_STOP: begin
                if (timer_q == '0) begin
                    state_d = TX_IDLE;
                end else begin
                    timer_d = timer_q - DIV_ONE;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level is derived from the next state and registered, so o_tx
        // is glitch-free and changes exactly on state boundaries.
        case (state_d)
            TX_START: line_d = 1'b0;
            TX_DATA:  line_d = shift_d[0];
            default:  line_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= TX_IDLE;
            timer_q     <= '0;
            frame_div_q <= DIV_ONE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            line_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            frame_div_q <= frame_div_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            line_q      <= line_d;
        end
    end

    assign o_tx = line_q;

endmodule
